// File: rtl/seg7_scan_if.sv
// seg7_scan_if: display-value, decoder and display-drive signals of the seven-segment scan controller
interface seg7_scan_if #(parameter int NUM_DIGITS = 4);
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic load;
  logic lz_en;
  logic [3:0] dec_bcd;
  logic [6:0] dec_seg;
  logic [6:0] seg;
  logic [NUM_DIGITS-1:0] an;
  logic frame_done;
  modport master (output bcd_in, load, lz_en, dec_seg, input dec_bcd, seg, an, frame_done);
  modport slave (input bcd_in, load, lz_en, dec_seg, output dec_bcd, seg, an, frame_done);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed seven-segment scanner with blanking, leading-zero suppression and frame-synchronous double buffering
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input logic clk,
  input logic rst,
  seg7_scan_if.slave bus
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d, pending_q, pending_d;
  logic pend_v_q, pend_v_d, sup_q, sup_d, fd_q, fd_d;
  logic [3:0] dec_q, dec_d;
  logic [6:0] seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic slot_end, wrap;
  always_comb begin
    slot_end = cnt_q == CW'(REFRESH_DIV - 1);
    wrap = slot_end && idx_q == IW'(NUM_DIGITS - 1);
    cnt_d = slot_end ? '0 : cnt_q + CW'(1);
    idx_d = wrap ? '0 : slot_end ? idx_q + IW'(1) : idx_q;
    pending_d = bus.load ? bus.bcd_in : pending_q;
    pend_v_d = !wrap && (bus.load || pend_v_q);
    shadow_d = !wrap ? shadow_q : bus.load ? bus.bcd_in : pend_v_q ? pending_q : shadow_q;
    sup_d = slot_end ? (bus.lz_en && idx_d != '0 && (shadow_d >> {idx_d, 2'b00}) == '0) : sup_q;
    dec_d = slot_end ? shadow_d[{idx_d, 2'b00} +: 4] : dec_q;
    seg_d = (sup_q || dec_q > 4'd9) ? '0 : bus.dec_seg;
    an_d = cnt_d >= CW'(BLANK_CYCLES) ? ~(NUM_DIGITS'(1) << idx_d) : '1;
    fd_d = wrap;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      shadow_q <= '0;
      pending_q <= '0;
      pend_v_q <= 1'b0;
      sup_q <= 1'b0;
      dec_q <= '0;
      seg_q <= '0;
      an_q <= '1;
      fd_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shadow_q <= shadow_d;
      pending_q <= pending_d;
      pend_v_q <= pend_v_d;
      sup_q <= sup_d;
      dec_q <= dec_d;
      seg_q <= seg_d;
      an_q <= an_d;
      fd_q <= fd_d;
    end
  end
  assign bus.dec_bcd = dec_q;
  assign bus.seg = seg_q;
  assign bus.an = an_q;
  assign bus.frame_done = fd_q;
endmodule
